// File: rtl/nn_pkg.sv
// Shared constants and types for the drawing-grid front end: canvas geometry,
// key indices, FSM/step encodings and the pixel address helper.
package nn_pkg;

    localparam int GRID_W      = 28;
    localparam int GRID_H      = 28;
    localparam int GRID_PIXELS = 784;
    localparam int ADDR_W      = 10;
    localparam int COORD_W     = 5;

    localparam int KEY_DOWN  = 0;
    localparam int KEY_UP    = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Row-major address on a 28-wide canvas; y*28 built from shifts, max 783.
    function automatic logic [ADDR_W-1:0] pix_addr_f(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        logic [ADDR_W-1:0] yw;
        logic [ADDR_W-1:0] xw;
        yw = {5'd0, y};
        xw = {5'd0, x};
        return (yw << 4) + (yw << 3) + (yw << 2) + xw;
    endfunction

endpackage

// File: rtl/key_cursor_ctrl_if.sv
// Pixel-write / cursor bus from the key cursor controller to the grid RAM side.
interface key_cursor_ctrl_if;
    import nn_pkg::*;

    logic [COORD_W-1:0] cursor_x;
    logic [COORD_W-1:0] cursor_y;
    logic               pix_we;
    logic [ADDR_W-1:0]  pix_addr;
    logic               pix_data;
    logic               busy;

    modport master (output cursor_x, output cursor_y, output pix_we,
                    output pix_addr, output pix_data, output busy);
    modport slave  (input cursor_x, input cursor_y, input pix_we,
                    input pix_addr, input pix_data, input busy);
endinterface

// File: rtl/key_cursor_ctrl_debounce.sv
// One push-button input path: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on the accepted released->pressed transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise, count consecutive disagreeing samples, flip the level when stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                    press_r <= level_r;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/key_cursor_ctrl.sv
// Key-driven cursor on the 28x28 canvas with pixel write strobes and a clear sweep.
// Define CURSOR_WRAP_EN to wrap the cursor at canvas edges instead of clamping.
module key_cursor_ctrl
    import nn_pkg::*;
#(
    parameter int GRID_W          = nn_pkg::GRID_W,
    parameter int GRID_H          = nn_pkg::GRID_H,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        key_n,
    input  logic              draw_en,
    input  logic              clear,
    key_cursor_ctrl_if.master pix
);
    localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] X_HOME    = COORD_W'(GRID_W / 2);
    localparam logic [COORD_W-1:0] Y_HOME    = COORD_W'(GRID_H / 2);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(GRID_W * GRID_H - 1);

    logic [3:0]         press_s;
    logic               draw_q_r;
    logic               clear_q_r;
    logic               draw_rise_s;
    logic               clear_rise_s;
    state_t             state_r;
    state_t             state_s;
    dir_t               dir_r;
    dir_t               dir_s;
    logic [COORD_W-1:0] cur_x_r;
    logic [COORD_W-1:0] cur_y_r;
    logic [COORD_W-1:0] next_x_s;
    logic [COORD_W-1:0] next_y_s;
    logic [ADDR_W-1:0]  clr_addr_r;
    logic               pix_we_r;
    logic [ADDR_W-1:0]  pix_addr_r;
    logic               pix_data_r;
    logic               busy_r;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .key_n (key_n[k]),
            .press (press_s[k])
        );
    end

    assign draw_rise_s  = draw_en & ~draw_q_r;
    assign clear_rise_s = clear & ~clear_q_r;

    // Next state; a clear edge beats a press, simultaneous presses resolve down>up>left>right.
    always_comb begin
        state_s = state_r;
        dir_s   = dir_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_rise_s) begin
                    state_s = ST_CLEAR;
                end else if (|press_s) begin
                    state_s = ST_STEP;
                    if (press_s[KEY_DOWN])      dir_s = DIR_DOWN;
                    else if (press_s[KEY_UP])   dir_s = DIR_UP;
                    else if (press_s[KEY_LEFT]) dir_s = DIR_LEFT;
                    else                        dir_s = DIR_RIGHT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STEP:  state_s = ST_IDLE;
            ST_CLEAR: begin
                if (clr_addr_r == ADDR_LAST) state_s = ST_IDLE;
                else                         state_s = ST_CLEAR;
            end
            default:  state_s = ST_IDLE;
        endcase
    end

    // Cursor position after applying the latched step direction at the canvas edges.
    always_comb begin
        next_x_s = cur_x_r;
        next_y_s = cur_y_r;
        case (dir_r)
`ifdef CURSOR_WRAP_EN
            DIR_RIGHT: next_x_s = (cur_x_r == X_MAX) ? 5'd0 : cur_x_r + 5'd1;
            DIR_LEFT:  next_x_s = (cur_x_r == 5'd0) ? X_MAX : cur_x_r - 5'd1;
            DIR_DOWN:  next_y_s = (cur_y_r == Y_MAX) ? 5'd0 : cur_y_r + 5'd1;
            DIR_UP:    next_y_s = (cur_y_r == 5'd0) ? Y_MAX : cur_y_r - 5'd1;
`else
            DIR_RIGHT: next_x_s = (cur_x_r == X_MAX) ? cur_x_r : cur_x_r + 5'd1;
            DIR_LEFT:  next_x_s = (cur_x_r == 5'd0) ? cur_x_r : cur_x_r - 5'd1;
            DIR_DOWN:  next_y_s = (cur_y_r == Y_MAX) ? cur_y_r : cur_y_r + 5'd1;
            DIR_UP:    next_y_s = (cur_y_r == 5'd0) ? cur_y_r : cur_y_r - 5'd1;
`endif
            default: begin
                next_x_s = cur_x_r;
                next_y_s = cur_y_r;
            end
        endcase
    end

    // State, cursor and registered pixel-bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            dir_r      <= DIR_DOWN;
            draw_q_r   <= 1'b0;
            clear_q_r  <= 1'b0;
            cur_x_r    <= X_HOME;
            cur_y_r    <= Y_HOME;
            clr_addr_r <= '0;
            pix_we_r   <= 1'b0;
            pix_addr_r <= '0;
            pix_data_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            dir_r     <= dir_s;
            draw_q_r  <= draw_en;
            clear_q_r <= clear;
            pix_we_r  <= 1'b0;
            busy_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    clr_addr_r <= '0;
                    if ((state_s == ST_IDLE) && draw_rise_s) begin
                        pix_we_r   <= 1'b1;
                        pix_data_r <= 1'b1;
                        pix_addr_r <= pix_addr_f(cur_x_r, cur_y_r);
                    end
                end
                ST_STEP: begin
                    cur_x_r <= next_x_s;
                    cur_y_r <= next_y_s;
                    if (draw_en) begin
                        pix_we_r   <= 1'b1;
                        pix_data_r <= 1'b1;
                        pix_addr_r <= pix_addr_f(next_x_s, next_y_s);
                    end
                end
                ST_CLEAR: begin
                    pix_we_r   <= 1'b1;
                    pix_data_r <= 1'b0;
                    pix_addr_r <= clr_addr_r;
                    busy_r     <= 1'b1;
                    clr_addr_r <= clr_addr_r + 10'd1;
                end
                default: begin
                    clr_addr_r <= '0;
                end
            endcase
        end
    end

    assign pix.cursor_x = cur_x_r;
    assign pix.cursor_y = cur_y_r;
    assign pix.pix_we   = pix_we_r;
    assign pix.pix_addr = pix_addr_r;
    assign pix.pix_data = pix_data_r;
    assign pix.busy     = busy_r;

endmodule

// File: tb/tb_key_cursor_ctrl.sv
// Directed bench for key_cursor_ctrl: behavioural model compared every cycle,
// plus hand-computed checkpoints. Honours CURSOR_WRAP_EN like the design.
module tb_key_cursor_ctrl;
    localparam int DEB = 16;
    localparam int W   = 28;
    localparam int H   = 28;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic       draw_en;
    logic       clear;

    int n_cmp = 0;
    int n_bad = 0;

    key_cursor_ctrl_if pix();

    key_cursor_ctrl #(.GRID_W(W), .GRID_H(H), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk     (clk),
        .reset   (reset),
        .key_n   (key_n),
        .draw_en (draw_en),
        .clear   (clear),
        .pix     (pix)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int move(input int v, input int delta, input int max);
        int n;
        n = v + delta;
`ifdef CURSOR_WRAP_EN
        if (n < 0) n = max;
        else if (n > max) n = 0;
`else
        if (n < 0) n = 0;
        else if (n > max) n = max;
`endif
        return n;
    endfunction

    // dir: 0 down, 1 up, 2 left, 3 right
    function automatic int step_x(input int x, input int dir);
        if (dir == 2) return move(x, -1, W - 1);
        if (dir == 3) return move(x, 1, W - 1);
        return x;
    endfunction

    function automatic int step_y(input int y, input int dir);
        if (dir == 0) return move(y, 1, H - 1);
        if (dir == 1) return move(y, -1, H - 1);
        return y;
    endfunction

    function automatic int first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    // ---------------- behavioural model ----------------
    // A raw level is accepted after DEB consecutive differing samples; the
    // synchroniser and pulse register place the step decision 3 edges later.
    logic [3:0] m_acc, m_evt, m_d1, m_d2;
    int         m_run [4];
    int         m_x, m_y, m_dir, m_idx, m_addr;
    bit         m_step, m_clr, m_we, m_data, m_busy, m_draw_q, m_clear_q;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc <= 4'hF; m_evt <= 4'h0; m_d1 <= 4'h0; m_d2 <= 4'h0;
            for (int i = 0; i < 4; i++) m_run[i] <= 0;
            m_x <= W / 2; m_y <= H / 2; m_dir <= 0; m_idx <= 0; m_addr <= 0;
            m_step <= 1'b0; m_clr <= 1'b0; m_we <= 1'b0; m_data <= 1'b0;
            m_busy <= 1'b0; m_draw_q <= 1'b0; m_clear_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_n[i] != m_acc[i]) begin
                    if (m_run[i] == DEB - 1) begin
                        m_acc[i] <= key_n[i];
                        m_run[i] <= 0;
                        m_evt[i] <= m_acc[i];
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                        m_evt[i] <= 1'b0;
                    end
                end else begin
                    m_run[i] <= 0;
                    m_evt[i] <= 1'b0;
                end
            end
            m_d1 <= m_evt;
            m_d2 <= m_d1;
            m_draw_q  <= draw_en;
            m_clear_q <= clear;
            m_we   <= 1'b0;
            m_busy <= 1'b0;
            if (m_clr) begin
                m_we <= 1'b1; m_busy <= 1'b1; m_data <= 1'b0; m_addr <= m_idx;
                m_idx <= m_idx + 1;
                if (m_idx == W * H - 1) m_clr <= 1'b0;
            end else if (m_step) begin
                m_x <= step_x(m_x, m_dir);
                m_y <= step_y(m_y, m_dir);
                if (draw_en) begin
                    m_we <= 1'b1; m_data <= 1'b1;
                    m_addr <= step_y(m_y, m_dir) * W + step_x(m_x, m_dir);
                end
                m_step <= 1'b0;
            end else if (clear && !m_clear_q) begin
                m_clr <= 1'b1; m_idx <= 0;
            end else if (m_d2 != 4'h0) begin
                m_step <= 1'b1; m_dir <= first_set(m_d2);
            end else if (draw_en && !m_draw_q) begin
                m_we <= 1'b1; m_data <= 1'b1; m_addr <= m_y * W + m_x;
            end
        end
    end

    // ---------------- compare + monitor ----------------
    int we_cnt = 0, busy_cnt = 0, last_addr = 0, last_data = 0, clr_exp = 0;

    always @(negedge clk) begin
        check("cursor_x", int'(pix.cursor_x), m_x);
        check("cursor_y", int'(pix.cursor_y), m_y);
        check("pix_we", int'(pix.pix_we), int'(m_we));
        check("busy", int'(pix.busy), int'(m_busy));
        if (m_we) begin
            check("pix_addr", int'(pix.pix_addr), m_addr);
            check("pix_data", int'(pix.pix_data), int'(m_data));
        end
        if (reset) clr_exp = 0;
        if (pix.pix_we) begin
            we_cnt++;
            last_addr = int'(pix.pix_addr);
            last_data = int'(pix.pix_data);
            if (!pix.pix_data) begin
                check("sweep_order", int'(pix.pix_addr), clr_exp);
                clr_exp = (clr_exp == W * H - 1) ? 0 : clr_exp + 1;
            end
        end
        if (pix.busy) busy_cnt++;
    end

    task automatic press(input int idx, input int low_cyc, input int high_cyc);
        key_n[idx] = 1'b0;
        repeat (low_cyc) @(negedge clk);
        key_n[idx] = 1'b1;
        repeat (high_cyc) @(negedge clk);
    endtask

    int base_we, base_busy, x_end, found;

    initial begin
        reset = 1'b0; key_n = 4'hF; draw_en = 1'b0; clear = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_x", int'(pix.cursor_x), 14);
        check("rst_y", int'(pix.cursor_y), 14);
        check("rst_we", int'(pix.pix_we), 0);
        check("rst_busy", int'(pix.busy), 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: idle with keys released
        repeat (100) @(negedge clk);
        check("idle_we_cnt", we_cnt, 0);
        check("idle_busy_cnt", busy_cnt, 0);
        check("idle_x", int'(pix.cursor_x), 14);

        // draw_en rising edge writes the current pixel once
        draw_en = 1'b1;
        repeat (5) @(negedge clk);
        check("draw_rise_cnt", we_cnt, 1);
        check("draw_rise_addr", last_addr, 406);

        // 2: right held 40 cycles -> one step, one write
        base_we = we_cnt;
        key_n = 4'b0111;
        repeat (40) @(negedge clk);
        key_n = 4'hF;
        repeat (40) @(negedge clk);
        check("t2_we_cnt", we_cnt - base_we, 1);
        check("t2_x", int'(pix.cursor_x), 15);
        check("t2_y", int'(pix.cursor_y), 14);
        check("t2_addr", last_addr, 407);
        check("t2_data", last_data, 1);

        // 3: short glitch rejected, then 14 right presses to the edge
        base_we = we_cnt;
        press(3, 10, 40);
        check("glitch_we_cnt", we_cnt - base_we, 0);
        check("glitch_x", int'(pix.cursor_x), 15);
        base_we = we_cnt;
        for (int i = 0; i < 14; i++) press(3, 24, 24);
`ifdef CURSOR_WRAP_EN
        x_end = 1;
`else
        x_end = 27;
`endif
        check("edge_x", int'(pix.cursor_x), x_end);
        check("edge_we_cnt", we_cnt - base_we, 14);
        check("edge_addr", last_addr, 14 * 28 + x_end);

        // 4: down+right together -> down only
        base_we = we_cnt;
        key_n = 4'b0110;
        repeat (24) @(negedge clk);
        key_n = 4'hF;
        repeat (24) @(negedge clk);
        check("prio_y", int'(pix.cursor_y), 15);
        check("prio_x", int'(pix.cursor_x), x_end);
        check("prio_we_cnt", we_cnt - base_we, 1);
        check("prio_addr", last_addr, 15 * 28 + x_end);

        // 5: full clear sweep with an ignored press in the middle
        base_we = we_cnt; base_busy = busy_cnt;
        clear = 1'b1;
        repeat (100) @(negedge clk);
        press(1, 24, 24);
        for (int i = 0; i < 1500 && pix.busy; i++) @(negedge clk);
        check("sweep_done", int'(pix.busy), 0);
        check("sweep_busy_cnt", busy_cnt - base_busy, 784);
        check("sweep_we_cnt", we_cnt - base_we, 784);
        check("sweep_last_addr", last_addr, 783);
        check("sweep_last_data", last_data, 0);
        check("sweep_y", int'(pix.cursor_y), 15);
        check("sweep_x", int'(pix.cursor_x), x_end);
        clear = 1'b0;
        repeat (5) @(negedge clk);

        // 6: reset in the middle of a sweep
        clear = 1'b1;
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            @(negedge clk);
            if (pix.pix_we && pix.pix_addr == 10'd300) found = 1;
        end
        check("reach_addr_300", found, 1);
        #1 reset = 1'b1;
        #1;
        check("async_busy", int'(pix.busy), 0);
        check("async_we", int'(pix.pix_we), 0);
        check("async_addr", int'(pix.pix_addr), 0);
        check("async_x", int'(pix.cursor_x), 14);
        check("async_y", int'(pix.cursor_y), 14);
        clear = 1'b0; draw_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        base_we = we_cnt;
        repeat (50) @(negedge clk);
        check("post_rst_we_cnt", we_cnt - base_we, 0);
        check("post_rst_busy", int'(pix.busy), 0);
        press(2, 24, 24);
        check("post_rst_left_x", int'(pix.cursor_x), 13);
        check("post_rst_nodraw", we_cnt - base_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
